glyph_loader: RTL and testbench

//  Writer for the mini character ROM's write port (w_en/addr/in_data, 64-bit glyph).

---
 rtl/glyph_loader_pkg.sv | 19 +
 rtl/glyph_row_shifter.sv | 50 +++++
 rtl/glyph_loader.sv | 120 ++++++++++++
 tb/tb_glyph_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_loader_pkg.sv
// Shared geometry and FSM encoding for the glyph loader and its row shifter.
// Also intended for the pixel serializer that reuses glyph_row_shifter.
package glyph_loader_pkg;

    localparam int GL_ADDR_W = 4;
    localparam int GL_ROWS   = 8;
    localparam int GL_COLS   = 8;
    localparam int GL_DATA_W = GL_ROWS * GL_COLS;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_RDREQ   = 3'd3,
        S_CHECK   = 3'd4,
        S_FINISH  = 3'd5
    } gl_state_t;

endpackage

// File: rtl/glyph_row_shifter.sv
// Row counter plus shift register that packs ROWS bytes into one glyph word.
// full_o flags the transfer that completes a glyph; the word is stable until the next shift.
module glyph_row_shifter
    import glyph_loader_pkg::*;
#(
    parameter int ROWS = GL_ROWS,
    parameter int COLS = GL_COLS,
    localparam int DATA_W = ROWS * COLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [COLS-1:0]   byte_i,
    output logic [DATA_W-1:0] rows_o,
    output logic              full_o
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rows_q, rows_d;

    assign full_o = shift_i && (cnt_q == LAST_ROW);
    assign rows_o = rows_q;

    always_comb begin
        cnt_d  = cnt_q;
        rows_d = rows_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            // Oldest row drifts toward the MSBs, so row 0 ends at the top of the word.
            rows_d = {rows_q[DATA_W-COLS-1:0], byte_i};
            cnt_d  = full_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            rows_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rows_q <= rows_d;
        end
    end

endmodule

// File: rtl/glyph_loader.sv
// Streams glyph rows into the character ROM, one 64-bit glyph per slot,
// and verifies every slot by reading it back after the write.
module glyph_loader
    import glyph_loader_pkg::*;
#(
    parameter int ADDR_W = GL_ADDR_W,
    parameter int ROWS   = GL_ROWS,
    parameter int COLS   = GL_COLS,
    localparam int DATA_W = ROWS * COLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              byte_valid,
    input  logic [COLS-1:0]   byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_w_en,
    output logic [DATA_W-1:0] rom_wdata,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W:0] SLOTS   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

    gl_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic [ADDR_W:0]   count_clamped;
    logic              clear_rows;
    logic              shift_en;
    logic              rows_full;
    logic [DATA_W-1:0] glyph;

    assign count_clamped = (count > SLOTS) ? SLOTS : count;
    assign shift_en      = byte_valid && byte_ready;

    glyph_row_shifter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_rows),
        .shift_i (shift_en),
        .byte_i  (byte_data),
        .rows_o  (glyph),
        .full_o  (rows_full)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rem_d      = rem_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        clear_rows = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_d      = start_addr;
                    rem_d      = count_clamped;
                    error_d    = 1'b0;
                    clear_rows = 1'b1;
                    state_d    = (count_clamped == '0) ? S_FINISH : S_COLLECT;
                end
            end
            S_COLLECT: if (rows_full) state_d = S_WRITE;
            S_WRITE:   state_d = S_RDREQ;
            // One dead cycle so the ROM read sees the freshly written word, not the old one.
            S_RDREQ:   state_d = S_CHECK;
            S_CHECK: begin
                if ((rom_rdata != glyph) && !error_q) begin
                    error_d    = 1'b1;
                    err_addr_d = cur_q;
                end
                cur_d   = cur_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == REM_ONE) ? S_FINISH : S_COLLECT;
            end
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            rem_q      <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign byte_ready = (state_q == S_COLLECT);
    assign rom_w_en   = (state_q == S_WRITE);
    assign rom_wdata  = (state_q == S_WRITE) ? glyph : '0;
    assign rom_addr   = (state_q == S_IDLE) ? '0 : cur_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done       = (state_q == S_FINISH);
    assign error      = error_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_glyph_loader.sv
// Randomised bench for glyph_loader: a small ROM model plus a job-level reference
// that predicts written slots, glyph words, error flags and done timing.
module tb_glyph_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  start_addr = '0;
    logic [4:0]  count = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic [3:0]  rom_addr;
    logic        rom_w_en;
    logic [63:0] rom_wdata;
    logic [63:0] rom_rdata = '0;
    logic        busy, done, error;
    logic [3:0]  err_addr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int xfer_since = 0;
    logic [4:0]  corrupt = 5'h10;
    logic [63:0] mem [16];
    logic [7:0]  bytes_q [$];
    logic [3:0]  wr_addr_q [$];
    logic [63:0] wr_data_q [$];
    logic        wr_err_q [$];

    always #5 clk = ~clk;

    glyph_loader dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .rom_addr(rom_addr), .rom_w_en(rom_w_en), .rom_wdata(rom_wdata),
        .rom_rdata(rom_rdata), .busy(busy), .done(done), .error(error), .err_addr(err_addr)
    );

    // Character ROM: registered read returning old data on a same-cycle write.
    always @(posedge clk) begin
        if (rom_w_en) mem[rom_addr] <= ({1'b0, rom_addr} == corrupt) ? (rom_wdata ^ 64'h1) : rom_wdata;
        rom_rdata <= mem[rom_addr];
    end

    task automatic tick();
        bit xfer;
        xfer = byte_valid && byte_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (xfer) xfer_since++;
        if (rom_w_en) begin
            wr_addr_q.push_back(rom_addr);
            wr_data_q.push_back(rom_wdata);
            wr_err_q.push_back(error);
            checks++;
            if (xfer_since !== 8) begin
                failures++;
                $display("FAIL wen_after_8_rows cyc=%0d transfers=%0d required=8", cyc, xfer_since);
            end
            xfer_since = 0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        checks++;
        if (byte_ready && (!busy || rom_w_en)) begin
            failures++;
            $display("FAIL ready_outside_collect cyc=%0d busy=%0b w_en=%0b", cyc, busy, rom_w_en);
        end
        if (!busy && !done) begin
            checks++;
            if (rom_addr !== 4'd0 || rom_w_en !== 1'b0) begin
                failures++;
                $display("FAIL idle_outputs cyc=%0d addr=%0d w_en=%0b required 0/0", cyc, rom_addr, rom_w_en);
            end
        end
    endtask

    task automatic gen_bytes(input int n);
        bytes_q.delete();
        repeat (n) bytes_q.push_back(8'($urandom));
    endtask

    // mode: 0 continuous valid, 1 valid toggling every cycle, 2 random valid.
    task automatic run_job(input string name, input logic [3:0] sa, input logic [4:0] cnt,
                           input int mode, input bit pulse, output int start_to_done);
        int n_gl, nb, idx, t0, first_bad;
        bit v;
        logic [63:0] exp_word;
        logic [3:0] exp_slot;
        n_gl = (cnt > 5'd16) ? 16 : int'(cnt);
        nb = n_gl * 8;
        wr_addr_q.delete(); wr_data_q.delete(); wr_err_q.delete();
        done_cnt = 0; done_cyc = -1; xfer_since = 0;
        start = 1'b1; start_addr = sa; count = cnt; byte_valid = 1'b0;
        tick();
        t0 = cyc;
        start = 1'b0;
        idx = 0;
        v = 1'b0;
        while (done_cnt == 0 && cyc - t0 < 3000) begin
            if (pulse) begin
                start = ($urandom_range(0, 2) == 0);
                start_addr = 4'($urandom);
                count = 5'($urandom);
            end
            case (mode)
                0: v = 1'b1;
                1: v = ~v;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            byte_valid = v && (idx < nb);
            byte_data = byte_valid ? bytes_q[idx] : 8'($urandom);
            if (byte_valid && byte_ready) idx++;
            tick();
        end
        start = 1'b0; byte_valid = 1'b0;
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL %s_timeout no done within 3000 cycles", name);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL %s_done_count got=%0d required=1", name, done_cnt);
        end
        checks++;
        if (wr_addr_q.size() != n_gl) begin
            failures++;
            $display("FAIL %s_write_count got=%0d required=%0d", name, wr_addr_q.size(), n_gl);
        end
        first_bad = -1;
        for (int g = 0; g < n_gl && g < wr_addr_q.size(); g++) begin
            exp_slot = 4'((int'(sa) + g) % 16);
            exp_word = '0;
            for (int r = 0; r < 8; r++) exp_word = (exp_word << 8) | 64'(bytes_q[g * 8 + r]);
            checks++;
            if (wr_addr_q[g] !== exp_slot || wr_data_q[g] !== exp_word || wr_err_q[g] !== (first_bad >= 0)) begin
                failures++;
                $display("FAIL %s_write%0d got addr=%0d data=%h err=%0b required addr=%0d data=%h err=%0b",
                         name, g, wr_addr_q[g], wr_data_q[g], wr_err_q[g], exp_slot, exp_word, first_bad >= 0);
            end
            if (first_bad < 0 && {1'b0, exp_slot} == corrupt) first_bad = int'(exp_slot);
        end
        checks++;
        if (error !== (first_bad >= 0) || (first_bad >= 0 && err_addr !== 4'(first_bad))) begin
            failures++;
            $display("FAIL %s_error got error=%0b err_addr=%0d required error=%0b err_addr=%0d",
                     name, error, err_addr, first_bad >= 0, first_bad);
        end
        start_to_done = done_cyc - t0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({byte_ready, rom_w_en, busy, done, error} !== 5'b0 || rom_addr !== 4'd0 ||
            rom_wdata !== 64'd0 || err_addr !== 4'd0) begin
            failures++;
            $display("FAIL %s got ready=%0b w_en=%0b busy=%0b done=%0b error=%0b addr=%0d err_addr=%0d wdata=%h required all 0",
                     name, byte_ready, rom_w_en, busy, done, error, rom_addr, err_addr, rom_wdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            tick();
            check_all_zero("reset_outputs");
        end
        rst = 1'b0;
        tick();
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_basic();
        int lat;
        bytes_q = '{8'h30, 8'h70, 8'h30, 8'h30, 8'h30, 8'h30, 8'hFC, 8'h00};
        run_job("basic", 4'd3, 5'd1, 0, 1'b0, lat);
        checks++;
        if (lat !== 11) begin
            failures++;
            $display("FAIL basic_latency got=%0d required=11", lat);
        end
        checks++;
        if (wr_data_q.size() != 1 || wr_data_q[0] !== 64'h307030303030FC00) begin
            failures++;
            $display("FAIL basic_word got=%h required=307030303030fc00", wr_data_q.size() ? wr_data_q[0] : 64'hx);
        end
    endtask

    task automatic test_wrap();
        int lat;
        gen_bytes(16);
        run_job("wrap", 4'd15, 5'd2, 0, 1'b0, lat);
        checks++;
        if (lat !== 22) begin
            failures++;
            $display("FAIL wrap_latency got=%0d required=22", lat);
        end
    endtask

    task automatic test_toggle_valid();
        int lat;
        bytes_q = '{8'h30, 8'h70, 8'h30, 8'h30, 8'h30, 8'h30, 8'hFC, 8'h00};
        run_job("toggle", 4'd3, 5'd1, 1, 1'b0, lat);
    endtask

    task automatic test_corrupt();
        int lat;
        corrupt = 5'd5;
        gen_bytes(24);
        run_job("corrupt", 4'd4, 5'd3, 2, 1'b0, lat);
        corrupt = 5'h10;
        repeat (5) tick();
        checks++;
        if (error !== 1'b1 || err_addr !== 4'd5) begin
            failures++;
            $display("FAIL error_sticky got error=%0b err_addr=%0d required 1/5", error, err_addr);
        end
    endtask

    task automatic test_count_edges();
        int lat;
        bytes_q.delete();
        run_job("count0", 4'd7, 5'd0, 0, 1'b0, lat);
        checks++;
        if (lat < 0 || lat > 2) begin
            failures++;
            $display("FAIL count0_done_delay got=%0d required<=2", lat);
        end
        gen_bytes(128);
        run_job("count20", 4'd9, 5'd20, 0, 1'b0, lat);
        checks++;
        if (lat !== 176) begin
            failures++;
            $display("FAIL count20_latency got=%0d required=176", lat);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        for (int j = 0; j < 3; j++) begin
            gen_bytes(24);
            run_job("busy_start", 4'($urandom), 5'($urandom_range(1, 3)), 2, 1'b1, lat);
        end
    endtask

    task automatic test_reset_midjob();
        int lat;
        int fed;
        gen_bytes(16);
        wr_addr_q.delete();
        start = 1'b1; start_addr = 4'd2; count = 5'd2;
        tick();
        start = 1'b0;
        fed = 0;
        for (int k = 0; k < 20 && fed < 4; k++) begin
            byte_valid = 1'b1;
            byte_data = bytes_q[fed];
            if (byte_ready) fed++;
            tick();
        end
        byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_all_zero("midjob_reset");
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (wr_addr_q.size() != 0) begin
            failures++;
            $display("FAIL midjob_no_write got=%0d writes required=0", wr_addr_q.size());
        end
        gen_bytes(8);
        run_job("after_reset", 4'd9, 5'd1, 0, 1'b0, lat);
    endtask

    task automatic test_random();
        int lat;
        for (int j = 0; j < 4; j++) begin
            gen_bytes(40);
            run_job("random", 4'($urandom), 5'($urandom_range(1, 5)), $urandom_range(0, 2), 1'b0, lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_toggle_valid();
        test_corrupt();
        test_count_edges();
        test_start_ignored();
        test_reset_midjob();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
